// File: rtl/nibble_serial_add_ctrl.sv
// Serial adder controller: streams NIBBLES 4-bit slices through an external registered
// CLA stage (2-cycle latency), chaining carries at full throughput, and returns the W+1-bit sum.
module nibble_serial_add_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   cin_in,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES:0]     result,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [4:0]             add_c
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned CW = $clog2(NIBBLES + 1);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic          accept, last_cap;
  logic          issue_v, issue_first, cin_v, cin_first, cap_v, cin_q;
  logic [W-1:0]  a_sh, b_sh, acc;
  logic [CW-1:0] iss_cnt, cap_cnt;

  assign accept   = start && (state != RUN);
  assign last_cap = cap_v && (cap_cnt == LAST);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = start ? RUN : IDLE;
      RUN:        if (last_cap) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // cin_v marks the cycle after an issue; the stage's live carry-out then belongs
  // to the previous nibble, except for nibble 0 which takes the latched carry-in.
  always_comb begin
    add_cin = 1'b0;
    if (cin_v) add_cin = cin_first ? cin_q : add_c[4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      issue_v     <= 1'b0;
      issue_first <= 1'b0;
      cin_v       <= 1'b0;
      cin_first   <= 1'b0;
      cap_v       <= 1'b0;
      cin_q       <= 1'b0;
      a_sh        <= '0;
      b_sh        <= '0;
      acc         <= '0;
      iss_cnt     <= '0;
      cap_cnt     <= '0;
      add_a       <= '0;
      add_b       <= '0;
      result      <= '0;
    end else begin
      state       <= state_nx;
      issue_first <= accept;
      cin_v       <= issue_v;
      cin_first   <= issue_first;
      cap_v       <= cin_v;

      if (accept) begin
        add_a   <= op_a[3:0];
        add_b   <= op_b[3:0];
        a_sh    <= op_a >> 4;
        b_sh    <= op_b >> 4;
        cin_q   <= cin_in;
        acc     <= '0;
        iss_cnt <= '0;
        cap_cnt <= '0;
        issue_v <= 1'b1;
      end else if (issue_v && (iss_cnt != LAST)) begin
        add_a   <= a_sh[3:0];
        add_b   <= b_sh[3:0];
        a_sh    <= a_sh >> 4;
        b_sh    <= b_sh >> 4;
        iss_cnt <= iss_cnt + 1'b1;
      end else begin
        add_a   <= '0;
        add_b   <= '0;
        issue_v <= 1'b0;
      end

      // Sum nibbles enter at the top so nibble 0 ends at the LSB after NIBBLES captures.
      if (cap_v) begin
        acc <= {add_c[3:0], acc[W-1:4]};
        if (!last_cap) cap_cnt <= cap_cnt + 1'b1;
      end

      if (last_cap) result <= {add_c[4], add_c[3:0], acc[W-1:4]};
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: behavioural CLA stage per instance, per-cycle trace,
// directed scenarios plus random vectors checked against plain integer addition.
module tb_nibble_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // NIBBLES=4 instance
  logic        st4 = 1'b0, ci4 = 1'b0;
  logic [15:0] a4 = '0, b4 = '0;
  logic        busy4, done4, acin4;
  logic [16:0] res4;
  logic [3:0]  aa4, ab4;
  logic [4:0]  ac4;

  // NIBBLES=2 instance
  logic        st2 = 1'b0, ci2 = 1'b0;
  logic [7:0]  a2 = '0, b2 = '0;
  logic        busy2, done2, acin2;
  logic [8:0]  res2;
  logic [3:0]  aa2, ab2;
  logic [4:0]  ac2;

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(st4), .op_a(a4), .op_b(b4), .cin_in(ci4),
    .busy(busy4), .done(done4), .result(res4), .add_a(aa4), .add_b(ab4),
    .add_cin(acin4), .add_c(ac4)
  );

  nibble_serial_add_ctrl #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(st2), .op_a(a2), .op_b(b2), .cin_in(ci2),
    .busy(busy2), .done(done2), .result(res2), .add_a(aa2), .add_b(ab2),
    .add_cin(acin2), .add_c(ac2)
  );

  // Registered adder stage: operands latched, cin taken live the next cycle, c one edge later.
  logic [3:0] ra4 = '0, rb4 = '0, ra2 = '0, rb2 = '0;
  always @(posedge clk) begin
    ra4 <= aa4; rb4 <= ab4; ac4 <= 5'(ra4) + 5'(rb4) + 5'(acin4);
    ra2 <= aa2; rb2 <= ab2; ac2 <= 5'(ra2) + 5'(rb2) + 5'(acin2);
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [16:0] tr_res4 [1024];
  logic [8:0]  tr_res2 [1024];
  logic [3:0]  tr_a4 [1024], tr_b4 [1024];
  logic        tr_cin4 [1024], tr_busy4 [1024], tr_done4 [1024];
  logic        tr_busy2 [1024], tr_done2 [1024];

  always @(negedge clk) begin
    tr_res4[cyc & 1023]  <= res4;
    tr_a4[cyc & 1023]    <= aa4;
    tr_b4[cyc & 1023]    <= ab4;
    tr_cin4[cyc & 1023]  <= acin4;
    tr_busy4[cyc & 1023] <= busy4;
    tr_done4[cyc & 1023] <= done4;
    tr_res2[cyc & 1023]  <= res2;
    tr_busy2[cyc & 1023] <= busy2;
    tr_done2[cyc & 1023] <= done2;
  end

  function automatic int ix(input int c);
    return c & 1023;
  endfunction

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Starts a NIBBLES=4 run in the current cycle and returns once cycle s+8 has been traced.
  task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic ci, output int s);
    s = cyc;
    st4 = 1'b1; a4 = a; b4 = b; ci4 = ci;
    tick(1);
    st4 = 1'b0;
    tick(8);
  endtask

  initial begin
    int s;
    int exp4, exp2;
    logic saw;
    logic [15:0] ra, rb;
    logic [7:0]  qa, qb;
    logic        rc, qc;

    tick(3);
    check("reset busy",   busy4, 0);
    check("reset done",   done4, 0);
    check("reset result", res4, 0);
    check("reset add_a",  aa4, 0);
    check("reset add_b",  ab4, 0);
    check("reset add_cin", acin4, 0);
    rst = 1'b0;
    tick(2);

    // Basic add
    run4(16'h1234, 16'h0FCD, 1'b0, s);
    for (int k = 0; k < 4; k++)
      check("basic add_a seq", tr_a4[ix(s + 1 + k)], (64'h1234 >> (4 * k)) & 64'hF);
    check("basic add_a idle", tr_a4[ix(s + 5)], 0);
    check("basic busy c1", tr_busy4[ix(s + 1)], 1);
    check("basic busy c6", tr_busy4[ix(s + 6)], 1);
    check("basic busy c7", tr_busy4[ix(s + 7)], 0);
    check("basic early done", tr_done4[ix(s + 6)], 0);
    check("basic done c7", tr_done4[ix(s + 7)], 1);
    check("basic late done", tr_done4[ix(s + 8)], 0);
    check("basic result", tr_res4[ix(s + 7)], 64'h02201);
    check("basic result hold", tr_res4[ix(s + 8)], 64'h02201);

    // Full ripple
    run4(16'hFFFF, 16'h0001, 1'b0, s);
    check("ripple cin c2", tr_cin4[ix(s + 2)], 0);
    check("ripple cin c3", tr_cin4[ix(s + 3)], 1);
    check("ripple cin c4", tr_cin4[ix(s + 4)], 1);
    check("ripple cin c5", tr_cin4[ix(s + 5)], 1);
    check("ripple cin c6", tr_cin4[ix(s + 6)], 0);
    check("ripple result", tr_res4[ix(s + 7)], 64'h10000);

    // Max operands with carry-in
    run4(16'hFFFF, 16'hFFFF, 1'b1, s);
    check("max cin c2", tr_cin4[ix(s + 2)], 1);
    check("max result", tr_res4[ix(s + 7)], 64'h1FFFF);

    // Busy rejection and back-to-back start in the done cycle
    s = cyc;
    st4 = 1'b1; a4 = 16'h0001; b4 = 16'h0001; ci4 = 1'b0;
    tick(1); st4 = 1'b0;
    tick(2);
    st4 = 1'b1; a4 = 16'hAAAA; b4 = 16'h5555; ci4 = 1'b1;
    tick(1); st4 = 1'b0;
    tick(3);
    st4 = 1'b1; a4 = 16'h8000; b4 = 16'h8000; ci4 = 1'b0;
    tick(1); st4 = 1'b0;
    tick(7);
    check("b2b run1 done", tr_done4[ix(s + 7)], 1);
    check("b2b run1 result", tr_res4[ix(s + 7)], 64'h00002);
    check("b2b run2 busy", tr_busy4[ix(s + 8)], 1);
    check("b2b run2 early done", tr_done4[ix(s + 13)], 0);
    check("b2b run2 done", tr_done4[ix(s + 14)], 1);
    check("b2b run2 result", tr_res4[ix(s + 14)], 64'h10000);

    // Reset mid-run
    s = cyc;
    st4 = 1'b1; a4 = 16'h1234; b4 = 16'h1111; ci4 = 1'b0;
    tick(1); st4 = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1); rst = 1'b0;
    tick(9);
    check("midrst busy",   tr_busy4[ix(s + 4)], 0);
    check("midrst result", tr_res4[ix(s + 4)], 0);
    check("midrst add_a",  tr_a4[ix(s + 4)], 0);
    check("midrst add_b",  tr_b4[ix(s + 4)], 0);
    check("midrst add_cin", tr_cin4[ix(s + 4)], 0);
    saw = 1'b0;
    for (int c = 4; c <= 12; c++) saw |= tr_done4[ix(s + c)];
    check("midrst no done", saw, 0);
    check("midrst result later", tr_res4[ix(s + 12)], 0);

    // rst and start together: start dropped
    s = cyc;
    rst = 1'b1; st4 = 1'b1; a4 = 16'h0F0F; b4 = 16'h0101;
    tick(1); rst = 1'b0; st4 = 1'b0;
    tick(2);
    check("rst+start busy", tr_busy4[ix(s + 1)], 0);

    // NIBBLES=2 directed
    s = cyc;
    st2 = 1'b1; a2 = 8'hFF; b2 = 8'h01; ci2 = 1'b1;
    tick(1); st2 = 1'b0;
    tick(6);
    check("n2 early done", tr_done2[ix(s + 4)], 0);
    check("n2 busy c4", tr_busy2[ix(s + 4)], 1);
    check("n2 done c5", tr_done2[ix(s + 5)], 1);
    check("n2 result", tr_res2[ix(s + 5)], 64'h101);

    // Random vectors on both instances, with a stray start while busy half the time
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      qa = 8'($urandom);  qb = 8'($urandom);  qc = 1'($urandom);
      exp4 = int'(ra) + int'(rb) + int'(rc);
      exp2 = int'(qa) + int'(qb) + int'(qc);
      s = cyc;
      st4 = 1'b1; a4 = ra; b4 = rb; ci4 = rc;
      st2 = 1'b1; a2 = qa; b2 = qb; ci2 = qc;
      tick(1);
      st4 = 1'b0; st2 = 1'b0;
      tick(1);
      if ($urandom_range(1, 0) == 1) begin
        st4 = 1'b1; a4 = 16'($urandom); b4 = 16'($urandom);
        st2 = 1'b1; a2 = 8'($urandom);  b2 = 8'($urandom);
      end
      tick(1);
      st4 = 1'b0; st2 = 1'b0;
      tick(5 + $urandom_range(2, 0));
      check("rand4 done",   tr_done4[ix(s + 7)], 1);
      check("rand4 result", tr_res4[ix(s + 7)], 64'(exp4));
      check("rand2 done",   tr_done2[ix(s + 5)], 1);
      check("rand2 result", tr_res2[ix(s + 5)], 64'(exp2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
